instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 160 ++++++++++++++++
 tb/tb_instr_encoder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder
//   Packs instruction fields into 32-bit words and streams them into an
//   instruction memory at consecutive byte addresses.  Accepted legal words
//   go through a small FIFO; illegal ones are dropped and latch a sticky ERR.
//
// Ports
//   CLK        rising-edge clock
//   RST        synchronous active-high reset
//   IN_VALID   instruction fields valid
//   IN_READY   FIFO not full; an accept is IN_VALID & IN_READY
//   IN_CLASS   00 data-proc, 01 memory, 10 branch, 11 illegal
//   IN_COND    condition (EQ=0000, NE=0001, AL=1110)
//   IN_CMD     data-proc command
//   IN_LOAD    memory class: 1 LDR, 0 STR
//   IN_LINK    branch class: 1 BL, 0 B
//   IN_RN      base / first operand register
//   IN_RD      destination register
//   IN_IMM     Rm / imm12 / imm24 depending on class
//   MEM_WE     write request (FIFO not empty)
//   MEM_ADDR   byte address of the current write
//   MEM_WD     encoded word at FIFO head
//   MEM_READY  memory takes the write this cycle
//   ERR        sticky illegal-instruction flag

module instr_encoder #(
   parameter int DEPTH = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        IN_VALID,
   output logic        IN_READY,
   input  logic [1:0]  IN_CLASS,
   input  logic [3:0]  IN_COND,
   input  logic [3:0]  IN_CMD,
   input  logic        IN_LOAD,
   input  logic        IN_LINK,
   input  logic [3:0]  IN_RN,
   input  logic [3:0]  IN_RD,
   input  logic [23:0] IN_IMM,
   output logic        MEM_WE,
   output logic [31:0] MEM_ADDR,
   output logic [31:0] MEM_WD,
   input  logic        MEM_READY,
   output logic        ERR
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("instr_encoder: DEPTH must be a power of two and at least 2");
   end

   logic [31:0]   fifo_mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [31:0]   addr_q;
   logic [31:0]   addr_d;
   logic          err_q;

   logic          full;
   logic          empty;
   logic          accept;
   logic          illegal;
   logic          push;
   logic          pop;
   logic          cond_ok;
   logic          cmd_ok;
   logic [31:0]   word;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

   // Ready comes only from registered occupancy, so a same-cycle pop never
   // opens room for a push.
   assign IN_READY = ~full;
   assign accept   = IN_VALID & ~full;

   always_comb begin
      cond_ok = 1'b0;
      case (IN_COND)
         4'b0000, 4'b0001, 4'b1110: cond_ok = 1'b1;
         default:                   cond_ok = 1'b0;
      endcase
   end

   always_comb begin
      cmd_ok = 1'b0;
      case (IN_CMD)
         4'b0100, 4'b0010, 4'b0000,
         4'b1100, 4'b1101, 4'b1010: cmd_ok = 1'b1;
         default:                   cmd_ok = 1'b0;
      endcase
   end

   assign illegal = (IN_CLASS == 2'b11) | ~cond_ok |
                    ((IN_CLASS == 2'b00) & ~cmd_ok);

   assign push = accept & ~illegal;
   assign pop  = ~empty & MEM_READY;

   always_comb begin
      word = {IN_COND, IN_CLASS, 26'd0};
      case (IN_CLASS)
         2'b00:   word[25:0] = {1'b0, IN_CMD, 1'b0, IN_RN, IN_RD, 8'h00, IN_IMM[3:0]};
         2'b01:   word[25:0] = {5'b00000, IN_LOAD, IN_RN, IN_RD, IN_IMM[11:0]};
         2'b10:   word[25:0] = {1'b1, IN_LINK, IN_IMM};
         default: word[25:0] = 26'd0;
      endcase
   end

   // Address register is reloaded every cycle from addr_d so it only moves
   // on a completed write and wraps naturally at 2^32.
   always_comb begin
      addr_d = addr_q;
      if (pop) begin
         addr_d = addr_q + 32'd4;
      end
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         fifo_mem[wr_ptr] <= word;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         addr_q <= '0;
         err_q  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         addr_q <= addr_d;
         if (accept && illegal) begin
            err_q <= 1'b1;
         end
      end
   end

   assign MEM_WE   = ~empty;
   assign MEM_WD   = fifo_mem[rd_ptr];
   assign MEM_ADDR = addr_q;
   assign ERR      = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_class;
   logic [3:0]  in_cond;
   logic [3:0]  in_cmd;
   logic        in_load;
   logic        in_link;
   logic [3:0]  in_rn;
   logic [3:0]  in_rd;
   logic [23:0] in_imm;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic        mem_ready;
   logic        err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   instr_encoder #(.DEPTH(4)) dut (
      .CLK       (clk),
      .RST       (rst),
      .IN_VALID  (in_valid),
      .IN_READY  (in_ready),
      .IN_CLASS  (in_class),
      .IN_COND   (in_cond),
      .IN_CMD    (in_cmd),
      .IN_LOAD   (in_load),
      .IN_LINK   (in_link),
      .IN_RN     (in_rn),
      .IN_RD     (in_rd),
      .IN_IMM    (in_imm),
      .MEM_WE    (mem_we),
      .MEM_ADDR  (mem_addr),
      .MEM_WD    (mem_wd),
      .MEM_READY (mem_ready),
      .ERR       (err)
   );

   task automatic drive(input logic [1:0] c, input logic [3:0] cond, input logic [3:0] cmd,
                        input logic ld, input logic lk, input logic [3:0] rn,
                        input logic [3:0] rd, input logic [23:0] imm);
      in_class = c;
      in_cond  = cond;
      in_cmd   = cmd;
      in_load  = ld;
      in_link  = lk;
      in_rn    = rn;
      in_rd    = rd;
      in_imm   = imm;
      in_valid = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      mem_ready = 1'b0;
      drive(2'b00, 4'hE, 4'h4, 1'b0, 1'b0, 4'h0, 4'h0, 24'h0);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", mem_we); end
      total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=00000000", mem_addr); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_add();
      do_reset();
      mem_ready = 1'b1;
      drive(2'b00, 4'hE, 4'h4, 1'b0, 1'b0, 4'd2, 4'd1, 24'h000003);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL add_we got=%b exp=1", mem_we); end
      total++; if (mem_wd !== 32'hE0821003) begin bad++; $display("FAIL add_wd got=%h exp=E0821003", mem_wd); end
      total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL add_addr got=%h exp=00000000", mem_addr); end
      @(posedge clk);
      @(negedge clk);
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL add_done_we got=%b exp=0", mem_we); end
      total++; if (mem_addr !== 32'h4) begin bad++; $display("FAIL add_done_addr got=%h exp=00000004", mem_addr); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      mem_ready = 1'b1;
      drive(2'b01, 4'hE, 4'h0, 1'b1, 1'b0, 4'd5, 4'd4, 24'h000008);
      @(posedge clk);
      @(negedge clk);
      total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL b2b_we0 got=%b exp=1", mem_we); end
      total++; if (mem_wd !== 32'hE4154008) begin bad++; $display("FAIL b2b_wd0 got=%h exp=E4154008", mem_wd); end
      total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL b2b_addr0 got=%h exp=00000000", mem_addr); end
      drive(2'b10, 4'h0, 4'h0, 1'b0, 1'b1, 4'd9, 4'd9, 24'h000010);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL b2b_we1 got=%b exp=1", mem_we); end
      total++; if (mem_wd !== 32'h0B000010) begin bad++; $display("FAIL b2b_wd1 got=%h exp=0B000010", mem_wd); end
      total++; if (mem_addr !== 32'h4) begin bad++; $display("FAIL b2b_addr1 got=%h exp=00000004", mem_addr); end
      @(posedge clk);
      @(negedge clk);
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL b2b_idle_we got=%b exp=0", mem_we); end
      total++; if (mem_addr !== 32'h8) begin bad++; $display("FAIL b2b_idle_addr got=%h exp=00000008", mem_addr); end
   endtask

   task automatic test_full();
      logic [31:0] w [5];
      do_reset();
      mem_ready = 1'b0;
      // LDR AL Rn=1 Rd=2 imm=0x010+i encodes as E4112010+i
      for (int i = 0; i < 5; i++) w[i] = 32'hE4112010 + 32'(i);
      for (int i = 0; i < 4; i++) begin
         total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_ready_pre%0d got=%b exp=1", i, in_ready); end
         drive(2'b01, 4'hE, 4'h0, 1'b1, 1'b0, 4'd1, 4'd2, 24'h000010 + 24'(i));
         @(posedge clk);
         @(negedge clk);
      end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready_drop got=%b exp=0", in_ready); end
      drive(2'b01, 4'hE, 4'h0, 1'b1, 1'b0, 4'd1, 4'd2, 24'h000014);
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_held_ready got=%b exp=0", in_ready); end
         total++; if (mem_wd !== w[0]) begin bad++; $display("FAIL full_held_wd got=%h exp=%h", mem_wd, w[0]); end
         total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL full_held_addr got=%h exp=00000000", mem_addr); end
      end
      mem_ready = 1'b1;
      for (int j = 0; j < 5; j++) begin
         if (j == 2) in_valid = 1'b0;
         total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL full_wr%0d_we got=%b exp=1", j, mem_we); end
         total++; if (mem_wd !== w[j]) begin bad++; $display("FAIL full_wr%0d_wd got=%h exp=%h", j, mem_wd, w[j]); end
         total++; if (mem_addr !== 32'(4 * j)) begin bad++; $display("FAIL full_wr%0d_addr got=%h exp=%h", j, mem_addr, 32'(4 * j)); end
         @(posedge clk);
         @(negedge clk);
      end
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL full_drain_we got=%b exp=0", mem_we); end
      total++; if (mem_addr !== 32'd20) begin bad++; $display("FAIL full_drain_addr got=%h exp=00000014", mem_addr); end
   endtask

   task automatic test_illegal();
      do_reset();
      mem_ready = 1'b1;
      // bad condition, illegal class, bad data-processing command
      for (int k = 0; k < 3; k++) begin
         case (k)
            0:       drive(2'b00, 4'hB, 4'h4, 1'b0, 1'b0, 4'd1, 4'd1, 24'h1);
            1:       drive(2'b11, 4'hE, 4'h4, 1'b0, 1'b0, 4'd1, 4'd1, 24'h1);
            default: drive(2'b00, 4'h1, 4'h7, 1'b0, 1'b0, 4'd1, 4'd1, 24'h1);
         endcase
         @(posedge clk);
         @(negedge clk);
         in_valid = 1'b0;
         total++; if (err !== 1'b1) begin bad++; $display("FAIL ill%0d_err got=%b exp=1", k, err); end
         total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL ill%0d_we got=%b exp=0", k, mem_we); end
         total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL ill%0d_addr got=%h exp=00000000", k, mem_addr); end
      end
      // ORR AL Rn=3 Rd=7 Rm=9 with junk upper immediate bits
      drive(2'b00, 4'hE, 4'hC, 1'b1, 1'b1, 4'd3, 4'd7, 24'hABCDE9);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL ill_next_we got=%b exp=1", mem_we); end
      total++; if (mem_wd !== 32'hE1837009) begin bad++; $display("FAIL ill_next_wd got=%h exp=E1837009", mem_wd); end
      total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL ill_next_addr got=%h exp=00000000", mem_addr); end
      total++; if (err !== 1'b1) begin bad++; $display("FAIL ill_sticky got=%b exp=1", err); end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_wrap();
      do_reset();
      mem_ready = 1'b0;
      force dut.addr_q = 32'hFFFFFFF8;
      @(posedge clk);
      @(negedge clk);
      release dut.addr_q;
      @(posedge clk);
      @(negedge clk);
      total++; if (mem_addr !== 32'hFFFFFFF8) begin bad++; $display("FAIL wrap_preset got=%h exp=FFFFFFF8", mem_addr); end
      mem_ready = 1'b1;
      // MOV NE Rd=2 Rm=5
      drive(2'b00, 4'h1, 4'hD, 1'b0, 1'b0, 4'd0, 4'd2, 24'h000005);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      total++; if (mem_wd !== 32'h11A02005) begin bad++; $display("FAIL wrap_wd0 got=%h exp=11A02005", mem_wd); end
      total++; if (mem_addr !== 32'hFFFFFFF8) begin bad++; $display("FAIL wrap_addr0 got=%h exp=FFFFFFF8", mem_addr); end
      @(posedge clk);
      @(negedge clk);
      total++; if (mem_addr !== 32'hFFFFFFFC) begin bad++; $display("FAIL wrap_top got=%h exp=FFFFFFFC", mem_addr); end
      // STR EQ Rn=1 Rd=6 imm12=FFF
      drive(2'b01, 4'h0, 4'h0, 1'b0, 1'b0, 4'd1, 4'd6, 24'h123FFF);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      total++; if (mem_wd !== 32'h04016FFF) begin bad++; $display("FAIL wrap_wd1 got=%h exp=04016FFF", mem_wd); end
      total++; if (mem_addr !== 32'hFFFFFFFC) begin bad++; $display("FAIL wrap_addr1 got=%h exp=FFFFFFFC", mem_addr); end
      @(posedge clk);
      @(negedge clk);
      total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL wrap_zero got=%h exp=00000000", mem_addr); end
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL wrap_we got=%b exp=0", mem_we); end
   endtask

   task automatic test_reset_flush();
      do_reset();
      mem_ready = 1'b1;
      drive(2'b10, 4'hE, 4'h0, 1'b0, 1'b0, 4'd0, 4'd0, 24'h000001);
      @(posedge clk);
      @(negedge clk);
      drive(2'b11, 4'hE, 4'h0, 1'b0, 1'b0, 4'd0, 4'd0, 24'h0);
      @(posedge clk);
      @(negedge clk);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(2'b10, 4'hE, 4'h0, 1'b0, 1'b0, 4'd0, 4'd0, 24'h000100 + 24'(i));
         @(posedge clk);
         @(negedge clk);
      end
      total++; if (mem_addr !== 32'h4) begin bad++; $display("FAIL flush_pre_addr got=%h exp=00000004", mem_addr); end
      total++; if (err !== 1'b1) begin bad++; $display("FAIL flush_pre_err got=%b exp=1", err); end
      rst = 1'b1;
      drive(2'b10, 4'hE, 4'h0, 1'b0, 1'b0, 4'd0, 4'd0, 24'h000777);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL flush_we got=%b exp=0", mem_we); end
      total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL flush_addr got=%h exp=00000000", mem_addr); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL flush_err got=%b exp=0", err); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
      mem_ready = 1'b1;
      // B AL imm=0x000042 encodes as EA000042
      drive(2'b10, 4'hE, 4'h0, 1'b0, 1'b0, 4'd3, 4'd3, 24'h000042);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      total++; if (mem_wd !== 32'hEA000042) begin bad++; $display("FAIL flush_next_wd got=%h exp=EA000042", mem_wd); end
      total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL flush_next_addr got=%h exp=00000000", mem_addr); end
      @(posedge clk);
      @(negedge clk);
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL flush_empty_we got=%b exp=0", mem_we); end
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      mem_ready = 1'b0;
      in_class = '0; in_cond = '0; in_cmd = '0; in_load = 1'b0; in_link = 1'b0;
      in_rn = '0; in_rd = '0; in_imm = '0;
      test_reset();
      test_add();
      test_back_to_back();
      test_full();
      test_illegal();
      test_wrap();
      test_reset_flush();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
